i2c_lcd_init_seq: RTL
=====================

Name: i2c_lcd_init_seq

Overview:
Controller that sequences an I2C single-byte write master to drive a PCF8574-backpacked HD44780 LCD in 4-bit mode.
- After reset it runs the fixed power-up/init command list, then accepts user command/character bytes.
- Each byte is split into nibbles; each nibble is strobed with two expander writes (EN=1, then EN=0).
- Sits between application logic and the shared byte-level I2C master.

Parameters:
CLK_HZ, 100000000, input clock frequency; microsecond prescaler = CLK_HZ/1000000 cycles
I2C_ADDR, 7'h27, 7-bit expander address driven on i2c_addr
PWRUP_US, 50000, delay after reset before first transaction
LONG_US, 5000, delay after first init nibble and after commands 0x01/0x02/0x03
SHORT_US, 100, delay after every other nibble/byte

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i2c_valid  out  1  transaction request to I2C master
i2c_ready  in  1  master accepts request when valid&&ready
i2c_addr  out  7  slave address, constant I2C_ADDR
i2c_data  out  8  expander byte
i2c_done  in  1  one-cycle pulse: transaction finished
i2c_nack  in  1  qualified by i2c_done; 1 = slave NACKed
char_valid  in  1  user byte request
char_ready  out  1  sequencer can accept a user byte
char_data  in  8  user byte
char_rs  in  1  0 = command, 1 = character data
init_done  out  1  init list complete
error  out  1  sticky NACK error

Behaviour:
- Clock/reset: one clock domain, clk; reset is asynchronous, active-low (rst_n).
- Reset values: i2c_valid=0, i2c_data=8'h00, char_ready=0, init_done=0, error=0. State = PWRUP. Counters cleared.
- Reset mid-transaction: i2c_valid drops immediately. Any later i2c_done is ignored.
- Expander byte format: {nibble[3:0], BL=1, EN, RW=0, RS}.
  - Example: command nibble 3 gives 0x3C (EN=1), then 0x38 (EN=0).
- Delays:
  - Microsecond tick every CLK_HZ/1000000 cycles; delay counter is 17 bits.
  - A delay of N us ends after N ticks.
  - A delay starts the cycle after the i2c_done of the EN=0 write.
- Request handshake:
  - i2c_valid is held, with stable data, until sampled with i2c_ready=1.
  - Then state WAIT_DONE; only one request outstanding.
  - i2c_done outside WAIT_DONE is ignored.
- States:
  - PWRUP: wait PWRUP_US, then go to NIB_EN1.
  - NIB_EN1: request the EN=1 byte.
  - WAIT_DONE: on done without NACK, the next step is NIB_EN0 or DELAY.
  - NIB_EN0: request the EN=0 byte.
  - DELAY: wait; then move to the next list item, or to IDLE.
  - IDLE: char_ready=1.
  - ERROR: terminal.
- Init list, in order (all RS=0):
  - nibble 3, then LONG_US
  - nibble 3, then SHORT_US
  - nibble 3, then SHORT_US
  - nibble 2, then SHORT_US
  - byte 0x28, then SHORT_US
  - byte 0x0C, then SHORT_US
  - byte 0x01, then LONG_US
  - byte 0x06, then SHORT_US
  - Total: 24 I2C writes.
- Full byte sequence: high nibble EN1/EN0, no delay between nibbles, low nibble EN1/EN0, then the byte's delay.
- init_done rises to 1 on entry to IDLE after the last init delay, and stays 1 until reset.
- User path:
  - char_ready=1 only in IDLE with init_done=1 and error=0.
  - On char_valid&&char_ready, char_data/char_rs are latched and char_ready=0 from the next cycle.
  - Delay is LONG_US if char_rs=0 and char_data is in {0x01,0x02,0x03}; otherwise SHORT_US.
  - char_ready returns to 1 on the cycle after the delay ends.
- NACK (i2c_done && i2c_nack):
  - error=1 (sticky), state ERROR.
  - i2c_valid=0 and char_ready=0 forever until reset.
  - init_done keeps its value.

Optional Feature:
Macro LCD_NACK_RETRY_EN.
- Defined: on NACK the same byte is re-requested, up to 3 retries (4 attempts). The retry count resets on each successful write. error is set only on the 4th consecutive NACK.
- Undefined: the first NACK enters ERROR.

Test Plan:
- Reset, with CLK_HZ=1000000, PWRUP_US=10, LONG_US=5, SHORT_US=2, and ready/done immediate -> first i2c_valid after 10 us; data sequence begins 0x3C,0x38,0x3C,0x38,0x3C,0x38,0x2C,0x28,0x2C,0x28,0x8C,0x88; 24 writes total; then init_done=1, char_ready=1.
- After init, char 'A' (0x41, rs=1) -> writes 0x4D,0x49,0x1D,0x19; 2 us gap; then char_ready=1.
- Command 0x01 (rs=0) -> writes 0x0C,0x08,0x1C,0x18; char_ready stays 0 for 5 us after the last done.
- i2c_ready held 0 for 20 cycles -> i2c_valid and i2c_data stable throughout; exactly one transaction issued.
- NACK on 5th write -> error=1, no further i2c_valid, init_done=0. With LCD_NACK_RETRY_EN and 2 NACKs -> the byte is repeated twice, init completes, error=0.
- rst_n low during WAIT_DONE, stray i2c_done after release -> outputs return to reset values; sequence restarts from PWRUP.

Source files
------------

// File: rtl/i2c_lcd_init_seq.sv
// i2c_lcd_init_seq: drives a PCF8574-backpacked HD44780 LCD in 4-bit mode
// through a shared byte-level I2C write master.
//
// After reset the block waits PWRUP_US, then plays the fixed init list.
// After that it accepts user command or character bytes. Each nibble is
// sent as two expander writes: EN=1, then EN=0.
//
// Expander byte format: {nibble, BL=1, EN, RW=0, RS}.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i2c_valid/ready         request handshake to the I2C master
//   i2c_addr, i2c_data      slave address (constant) and expander byte
//   i2c_done, i2c_nack      completion pulse and NACK flag
//   char_valid/ready        user byte handshake
//   char_data, char_rs      user byte; rs=0 command, rs=1 character data
//   init_done, error        init list finished / sticky NACK error
//
// Optional macro LCD_NACK_RETRY_EN: a NACKed byte is re-requested up to
// 3 times. error is raised only on the 4th consecutive NACK.
module i2c_lcd_init_seq #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter logic [6:0]  I2C_ADDR = 7'h27,
    parameter int unsigned PWRUP_US = 50000,
    parameter int unsigned LONG_US  = 5000,
    parameter int unsigned SHORT_US = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       i2c_valid,
    input  logic       i2c_ready,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_data,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic [7:0] char_data,
    input  logic       char_rs,
    output logic       init_done,
    output logic       error
);

    localparam int unsigned PRESC =
        (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [16:0] PWRUP_T = 17'(PWRUP_US);
    localparam logic [16:0] LONG_T  = 17'(LONG_US);
    localparam logic [16:0] SHORT_T = 17'(SHORT_US);

    typedef enum logic [2:0] {
        PWRUP,
        NIB_EN1,
        WAIT_DONE,
        NIB_EN0,
        DELAY,
        IDLE,
        ERROR
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [16:0]   dly_cnt;
    logic [2:0]    item;
    logic [7:0]    cur_byte;
    logic          cur_rs;
    logic          nib_only;
    logic          lo_phase;
    logic          en_phase;
    logic          long_dly;
    logic          user_mode;
`ifdef LCD_NACK_RETRY_EN
    logic [1:0]    retry_cnt;
`endif

    logic          tick;
    logic          dly_end;
    logic [16:0]   dly_tgt;
    logic [17:0]   dly_nxt;
    logic [3:0]    cur_nib;
    logic [2:0]    item_nxt;
    logic [7:0]    byte_nxt;
    logic          user_long;

    // Init list; items 0..3 are single nibbles taken from the high half.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        unique case (idx)
            3'd0, 3'd1, 3'd2: b = 8'h30;
            3'd3:             b = 8'h20;
            3'd4:             b = 8'h28;
            3'd5:             b = 8'h0C;
            3'd6:             b = 8'h01;
            default:          b = 8'h06;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] pack_byte(
        input logic [3:0] nib,
        input logic       en,
        input logic       rs
    );
        return {nib, 1'b1, en, 1'b0, rs};
    endfunction

    assign i2c_addr  = I2C_ADDR;
    assign tick      = (presc == PW'(PRESC - 1));
    assign dly_tgt   = (state == PWRUP) ? PWRUP_T
                     : (long_dly ? LONG_T : SHORT_T);
    assign dly_nxt   = {1'b0, dly_cnt} + 18'd1;
    // The delay ends on the tick that completes the N-th microsecond.
    assign dly_end   = tick && (dly_nxt >= {1'b0, dly_tgt});
    assign cur_nib   = lo_phase ? cur_byte[3:0] : cur_byte[7:4];
    assign item_nxt  = (state == PWRUP) ? 3'd0 : item + 3'd1;
    assign byte_nxt  = init_byte(item_nxt);
    assign user_long = !char_rs &&
                       (char_data inside {8'h01, 8'h02, 8'h03});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PWRUP;
            presc      <= '0;
            dly_cnt    <= '0;
            item       <= '0;
            cur_byte   <= '0;
            cur_rs     <= 1'b0;
            nib_only   <= 1'b0;
            lo_phase   <= 1'b0;
            en_phase   <= 1'b0;
            long_dly   <= 1'b0;
            user_mode  <= 1'b0;
            i2c_valid  <= 1'b0;
            i2c_data   <= 8'h00;
            char_ready <= 1'b0;
            init_done  <= 1'b0;
            error      <= 1'b0;
`ifdef LCD_NACK_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            // The microsecond prescaler only runs while a delay is active,
            // so every delay starts from a fresh tick phase.
            if (state == PWRUP || state == DELAY) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    dly_cnt <= dly_end ? '0 : dly_nxt[16:0];
                end
            end else begin
                presc   <= '0;
                dly_cnt <= '0;
            end

            unique case (state)
                PWRUP, DELAY: begin
                    if (dly_end) begin
                        if (state == DELAY &&
                            (user_mode || item == 3'd7)) begin
                            state      <= IDLE;
                            user_mode  <= 1'b0;
                            init_done  <= 1'b1;
                            char_ready <= 1'b1;
                        end else begin
                            item      <= item_nxt;
                            cur_byte  <= byte_nxt;
                            cur_rs    <= 1'b0;
                            nib_only  <= !item_nxt[2];
                            long_dly  <= (item_nxt == 3'd0) ||
                                         (item_nxt == 3'd6);
                            lo_phase  <= 1'b0;
                            i2c_valid <= 1'b1;
                            i2c_data  <= pack_byte(byte_nxt[7:4],
                                                   1'b1, 1'b0);
                            state     <= NIB_EN1;
                        end
                    end
                end

                NIB_EN1: begin
                    if (i2c_ready) begin
                        i2c_valid <= 1'b0;
                        en_phase  <= 1'b1;
                        state     <= WAIT_DONE;
                    end
                end

                NIB_EN0: begin
                    if (i2c_ready) begin
                        i2c_valid <= 1'b0;
                        en_phase  <= 1'b0;
                        state     <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (i2c_done && i2c_nack) begin
`ifdef LCD_NACK_RETRY_EN
                        // i2c_data still holds the NACKed byte.
                        if (retry_cnt != 2'd3) begin
                            retry_cnt <= retry_cnt + 2'd1;
                            i2c_valid <= 1'b1;
                            state     <= en_phase ? NIB_EN1 : NIB_EN0;
                        end else begin
                            error <= 1'b1;
                            state <= ERROR;
                        end
`else
                        error <= 1'b1;
                        state <= ERROR;
`endif
                    end else if (i2c_done) begin
`ifdef LCD_NACK_RETRY_EN
                        retry_cnt <= '0;
`endif
                        if (en_phase) begin
                            i2c_valid <= 1'b1;
                            i2c_data  <= pack_byte(cur_nib, 1'b0, cur_rs);
                            state     <= NIB_EN0;
                        end else if (!nib_only && !lo_phase) begin
                            lo_phase  <= 1'b1;
                            i2c_valid <= 1'b1;
                            i2c_data  <= pack_byte(cur_byte[3:0],
                                                   1'b1, cur_rs);
                            state     <= NIB_EN1;
                        end else begin
                            state <= DELAY;
                        end
                    end
                end

                IDLE: begin
                    if (char_valid && char_ready) begin
                        char_ready <= 1'b0;
                        cur_byte   <= char_data;
                        cur_rs     <= char_rs;
                        nib_only   <= 1'b0;
                        lo_phase   <= 1'b0;
                        long_dly   <= user_long;
                        user_mode  <= 1'b1;
                        i2c_valid  <= 1'b1;
                        i2c_data   <= pack_byte(char_data[7:4],
                                                1'b1, char_rs);
                        state      <= NIB_EN1;
                    end
                end

                ERROR: begin
                    i2c_valid  <= 1'b0;
                    char_ready <= 1'b0;
                end

                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule
